// File: rtl/vga_text_ctrl_pkg.sv
// Shared constants and types for the VGA text-mode controller.
//   - 640x480@60 timing defaults, text grid and cell geometry
//   - attribute bit index, cursor underline start row
//   - ctl_t: control bits that travel down the pixel pipeline
//   - cell_addr(): character buffer address from scan counters
package vga_text_ctrl_pkg;

  localparam int unsigned H_ACTIVE_DEF  = 640;
  localparam int unsigned H_FP_DEF      = 16;
  localparam int unsigned H_SYNC_DEF    = 96;
  localparam int unsigned H_BP_DEF      = 48;
  localparam int unsigned V_ACTIVE_DEF  = 480;
  localparam int unsigned V_FP_DEF      = 10;
  localparam int unsigned V_SYNC_DEF    = 2;
  localparam int unsigned V_BP_DEF      = 33;
  localparam logic        SYNC_POL_DEF  = 1'b0;
  localparam int unsigned BLINK_BIT_DEF = 4;

  localparam int unsigned CELL_W      = 8;
  localparam int unsigned CELL_H      = 16;
  localparam int unsigned COLS        = 80;
  localparam int unsigned ROWS        = 30;
  localparam int unsigned ATTR_INV    = 7;   // char_data bit selecting inverse video
  localparam int unsigned CURSOR_ROW0 = 14;  // cursor underline occupies scanlines 14..15

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic fs;   // this pixel is (0,0)
    logic cur;  // cursor underline pixel, already gated by blink
  } ctl_t;

  // row*80 + col as row*64 + row*16 + col; no multiplier needed.
  function automatic logic [11:0] cell_addr(input logic [9:0] h, input logic [9:0] v);
    logic [11:0] row;
    row = {6'd0, v[9:4]};
    return (row << 6) + (row << 4) + {5'd0, h[9:3]};
  endfunction

endpackage

// File: rtl/vga_text_ctrl_timing.sv
// vga_timing_gen: horizontal/vertical scan counters with raw (unpipelined)
// sync and display-enable, plus next-count values and the frame wrap strobe.
//   clk, rst_n   pixel clock, async active-low reset
//   h_cnt/v_cnt  current scan position
//   h_nxt/v_nxt  position the counters load on the next edge
//   hs/vs/de     raw sync (SYNC_POL = active level) and active-video flag
//   frame_end    last pixel of the last line; counters wrap on the next edge
module vga_timing_gen
  import vga_text_ctrl_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter logic        SYNC_POL = SYNC_POL_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic [9:0] h_nxt,
  output logic [9:0] v_nxt,
  output logic       hs,
  output logic       vs,
  output logic       de,
  output logic       frame_end
);

  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic line_end;

  assign line_end  = (h_cnt == H_LAST);
  assign frame_end = line_end && (v_cnt == V_LAST);

  always_comb begin
    h_nxt = line_end ? '0 : h_cnt + 10'd1;
    v_nxt = v_cnt;
    if (line_end) v_nxt = frame_end ? '0 : v_cnt + 10'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
    end
  end

  assign hs = ((h_cnt >= HS_START) && (h_cnt < HS_END)) ? SYNC_POL : ~SYNC_POL;
  assign vs = ((v_cnt >= VS_START) && (v_cnt < VS_END)) ? SYNC_POL : ~SYNC_POL;
  assign de = (h_cnt < 10'(H_ACTIVE)) && (v_cnt < 10'(V_ACTIVE));

endmodule

// File: rtl/vga_text_ctrl.sv
// vga_text_ctrl: 80x30 text-mode scan controller with 8x16 cells.
//   clk, rst_n       pixel clock, async active-low reset
//   char_addr/data   character buffer (1-clk sync read); data[7] = inverse video
//   font_*           glyph ROM lookup (ascii/row/col); font_pixel returns 1 clk later
//   cursor_en/x/y    cursor, latched once per frame at the vertical wrap
//   vga_hs/vs/de     sync and active video, aligned with vga_pixel
//   vga_pixel        mono pixel, 0 outside active video
//   frame_start      1-clk pulse with pixel (0,0) at the outputs
// Pipeline: counters -> (buffer read) -> (glyph read) -> output regs, 3 clk total.
module vga_text_ctrl
  import vga_text_ctrl_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = H_ACTIVE_DEF,
  parameter int unsigned H_FP      = H_FP_DEF,
  parameter int unsigned H_SYNC    = H_SYNC_DEF,
  parameter int unsigned H_BP      = H_BP_DEF,
  parameter int unsigned V_ACTIVE  = V_ACTIVE_DEF,
  parameter int unsigned V_FP      = V_FP_DEF,
  parameter int unsigned V_SYNC    = V_SYNC_DEF,
  parameter int unsigned V_BP      = V_BP_DEF,
  parameter logic        SYNC_POL  = SYNC_POL_DEF,
  parameter int unsigned BLINK_BIT = BLINK_BIT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [11:0] char_addr,
  input  logic [7:0]  char_data,
  output logic [6:0]  font_ascii,
  output logic [3:0]  font_row,
  output logic [2:0]  font_col,
  input  logic        font_pixel,
  input  logic        cursor_en,
  input  logic [6:0]  cursor_x,
  input  logic [4:0]  cursor_y,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic        vga_pixel,
  output logic        frame_start
);

  localparam ctl_t CTL_IDLE = '{hs: ~SYNC_POL, vs: ~SYNC_POL, de: 1'b0, fs: 1'b0, cur: 1'b0};

  logic [9:0] h_cnt, v_cnt, h_nxt, v_nxt;
  logic       raw_hs, raw_vs, raw_de, frame_end;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .SYNC_POL (SYNC_POL)
  ) u_timing (
    .clk       (clk),
    .rst_n     (rst_n),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .h_nxt     (h_nxt),
    .v_nxt     (v_nxt),
    .hs        (raw_hs),
    .vs        (raw_vs),
    .de        (raw_de),
    .frame_end (frame_end)
  );

  // Frame counter and per-frame cursor shadow.
  logic [7:0] frame_cnt;
  logic       sh_en;
  logic [6:0] sh_x;
  logic [4:0] sh_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      sh_en     <= 1'b0;
      sh_x      <= '0;
      sh_y      <= '0;
    end else if (frame_end) begin
      frame_cnt <= frame_cnt + 8'd1;
      sh_en     <= cursor_en;
      sh_x      <= cursor_x;
      sh_y      <= cursor_y;
    end
  end

  // Address is built from the next counter values so it is valid in the
  // same cycle as the counters it describes; the buffer's 1-clk read then
  // lines up with stage 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) char_addr <= '0;
    else        char_addr <= cell_addr(h_nxt, v_nxt);
  end

  // Stage 0 control bits.
  ctl_t s0, s1, s2;
  logic hit;

  always_comb begin
    hit = sh_en && (sh_x < 7'(COLS)) && (sh_y < 5'(ROWS)) &&
          (h_cnt[9:3] == sh_x) && (v_cnt[9:4] == {1'b0, sh_y});
    s0     = CTL_IDLE;
    s0.hs  = raw_hs;
    s0.vs  = raw_vs;
    s0.de  = raw_de;
    s0.fs  = (h_cnt == '0) && (v_cnt == '0);
    s0.cur = hit && (v_cnt[3:0] >= 4'(CURSOR_ROW0)) && frame_cnt[BLINK_BIT];
  end

  // Stage 1: character data arrives; glyph coordinates are registered.
  logic s1_run;
  logic s2_inv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= CTL_IDLE;
      s1_run   <= 1'b0;
      font_row <= '0;
      font_col <= '0;
    end else begin
      s1       <= s0;
      s1_run   <= 1'b1;
      font_row <= v_cnt[3:0];
      font_col <= h_cnt[2:0];
    end
  end

  // The buffer output is unregistered here; hold the lookup at 0 until the
  // first read after reset has landed.
  assign font_ascii = s1_run ? char_data[6:0] : '0;

  // Stage 2: glyph pixel arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2     <= CTL_IDLE;
      s2_inv <= 1'b0;
    end else begin
      s2     <= s1;
      s2_inv <= char_data[ATTR_INV];
    end
  end

  // Stage 3: registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_hs      <= ~SYNC_POL;
      vga_vs      <= ~SYNC_POL;
      vga_de      <= 1'b0;
      vga_pixel   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      vga_hs      <= s2.hs;
      vga_vs      <= s2.vs;
      vga_de      <= s2.de;
      vga_pixel   <= s2.de & (font_pixel ^ s2_inv ^ s2.cur);
      frame_start <= s2.fs;
    end
  end

endmodule
